// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer: FSM state, BCD time and
// minute-counter widths.
package alarm_pkg;

  localparam int MIN_CNT_W  = 4;
  localparam int SNZ_USED_W = 2;

  typedef logic [15:0] bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RINGING  = 2'd1,
    ST_SNOOZING = 2'd2,
    ST_DONE     = 2'd3
  } alarm_state_t;

  typedef struct packed {
    alarm_state_t         state;
    logic [MIN_CNT_W-1:0] ring_left;
  } alarm_dbg_t;

endpackage

// File: rtl/minute_countdown.sv
// Loadable 4-bit down-counter stepped by minute pulses. It saturates at zero and
// pulses o_tc on the step that takes it from 1 to 0.
module minute_countdown
  import alarm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [MIN_CNT_W-1:0] i_load_val,
  input  logic                 i_step,
  output logic [MIN_CNT_W-1:0] o_count,
  output logic                 o_tc
);

  logic [MIN_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_step && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Clear and load take precedence over a step, so no terminal pulse is raised then.
  assign o_tc    = i_step && !i_clear && !i_load && (r_count == MIN_CNT_W'(1));
  assign o_count = r_count;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencing controller: arms, rings, snoozes a limited number of times,
// times out ringing, and waits out the matching minute before re-arming.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MINUTES       = 9,
  parameter int RING_TIMEOUT_MINUTES = 10,
  parameter int MAX_SNOOZES          = 3
) (
  input  logic                  clk256,
  input  logic                  reset,
  input  logic                  one_minute,
  input  logic                  snooze,
  input  logic                  stop_alarm,
  input  logic                  alarm_enable,
  input  bcd_time_t             current_time,
  input  bcd_time_t             alarm_time,
  output logic                  sound_alarm,
  output logic                  snoozing,
  output logic [MIN_CNT_W-1:0]  snooze_left,
  output logic [SNZ_USED_W-1:0] snoozes_used,
  output logic                  armed,
  output alarm_dbg_t            dbg
);

  localparam logic [MIN_CNT_W-1:0]  SNZ_LOAD  = MIN_CNT_W'(SNOOZE_MINUTES);
  localparam logic [MIN_CNT_W-1:0]  RING_LOAD = MIN_CNT_W'(RING_TIMEOUT_MINUTES);
  localparam logic [SNZ_USED_W-1:0] SNZ_MAX   = SNZ_USED_W'(MAX_SNOOZES);

  alarm_state_t          r_state;
  alarm_state_t          w_next_state;
  logic                  r_sound;
  logic                  r_snoozing;
  logic                  r_armed;
  logic [SNZ_USED_W-1:0] r_snoozes_used;

  logic                  w_same_time;
  logic                  w_match;
  logic                  w_abort;
  logic                  w_snz_load;
  logic                  w_snz_step;
  logic                  w_snz_clear;
  logic                  w_snz_tc;
  logic                  w_ring_load;
  logic                  w_ring_step;
  logic                  w_ring_tc;
  logic [MIN_CNT_W-1:0]  w_snz_count;
  logic [MIN_CNT_W-1:0]  w_ring_count;

  assign w_same_time = (current_time == alarm_time);
  assign w_match     = alarm_enable && w_same_time;
  assign w_abort     = !alarm_enable || stop_alarm;

  // Disable beats stop, stop beats snooze, snooze beats the minute pulse.
  assign w_snz_load  = (r_state == ST_RINGING) && !w_abort && snooze
                       && (r_snoozes_used < SNZ_MAX);
  assign w_snz_step  = (r_state == ST_SNOOZING) && !w_abort && one_minute;
  assign w_snz_clear = (r_state == ST_SNOOZING) && w_abort;
  assign w_ring_step = (r_state == ST_RINGING) && !w_abort && !w_snz_load && one_minute;
  assign w_ring_load = ((r_state == ST_IDLE) && w_match) || w_snz_tc;

  minute_countdown u_snooze_timer (
    .clk        (clk256),
    .rst_n      (reset),
    .i_clear    (w_snz_clear),
    .i_load     (w_snz_load),
    .i_load_val (SNZ_LOAD),
    .i_step     (w_snz_step),
    .o_count    (w_snz_count),
    .o_tc       (w_snz_tc)
  );

  // Ring timeout counts down from the limit; reaching zero ends the event.
  minute_countdown u_ring_timer (
    .clk        (clk256),
    .rst_n      (reset),
    .i_clear    (1'b0),
    .i_load     (w_ring_load),
    .i_load_val (RING_LOAD),
    .i_step     (w_ring_step),
    .o_count    (w_ring_count),
    .o_tc       (w_ring_tc)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_match) w_next_state = ST_RINGING;
      end
      ST_RINGING: begin
        if (w_abort)         w_next_state = ST_DONE;
        else if (w_snz_load) w_next_state = ST_SNOOZING;
        else if (w_ring_tc)  w_next_state = ST_DONE;
      end
      ST_SNOOZING: begin
        if (w_abort)       w_next_state = ST_DONE;
        else if (w_snz_tc) w_next_state = ST_RINGING;
      end
      ST_DONE: begin
        if (alarm_enable && !w_same_time) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk256 or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_sound        <= 1'b0;
      r_snoozing     <= 1'b0;
      r_armed        <= 1'b0;
      r_snoozes_used <= '0;
    end else begin
      r_state    <= w_next_state;
      r_sound    <= (w_next_state == ST_RINGING);
      r_snoozing <= (w_next_state == ST_SNOOZING);
      r_armed    <= (w_next_state == ST_IDLE) && alarm_enable;
      if ((r_state == ST_IDLE) && w_match) begin
        r_snoozes_used <= '0;
      end else if (w_snz_load && (r_snoozes_used != '1)) begin
        r_snoozes_used <= r_snoozes_used + 1'b1;
      end
    end
  end

  assign sound_alarm   = r_sound;
  assign snoozing      = r_snoozing;
  assign snooze_left   = w_snz_count;
  assign snoozes_used  = r_snoozes_used;
  assign armed         = r_armed;
  assign dbg.state     = r_state;
  assign dbg.ring_left = w_ring_count;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed vector table, hand-written reset corner
// cases, then random stimulus against an event-level reference model.
module tb_alarm_sequencer;
  import alarm_pkg::*;

  localparam int SNZ_MIN = 9;
  localparam int RING_TO = 10;
  localparam int MAX_SNZ = 3;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;
  localparam int M_DONE = 3;

  logic        clk256 = 1'b0;
  logic        reset;
  logic        one_minute;
  logic        snooze;
  logic        stop_alarm;
  logic        alarm_enable;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        sound_alarm;
  logic        snoozing;
  logic [3:0]  snooze_left;
  logic [1:0]  snoozes_used;
  logic        armed;
  alarm_dbg_t  dbg;

  int n_cmp = 0;
  int n_bad = 0;

  int   m_mode, m_ring, m_left, m_used;
  logic m_armed;

  typedef struct {
    logic        om, sz, st, en;
    logic [15:0] cur;
    logic [8:0]  exp;
    string       name;
  } vec_t;

  vec_t vq[$];

  alarm_sequencer #(
    .SNOOZE_MINUTES       (SNZ_MIN),
    .RING_TIMEOUT_MINUTES (RING_TO),
    .MAX_SNOOZES          (MAX_SNZ)
  ) dut (
    .clk256       (clk256),
    .reset        (reset),
    .one_minute   (one_minute),
    .snooze       (snooze),
    .stop_alarm   (stop_alarm),
    .alarm_enable (alarm_enable),
    .current_time (current_time),
    .alarm_time   (alarm_time),
    .sound_alarm  (sound_alarm),
    .snoozing     (snoozing),
    .snooze_left  (snooze_left),
    .snoozes_used (snoozes_used),
    .armed        (armed),
    .dbg          (dbg)
  );

  always #5 clk256 = ~clk256;

  function automatic logic [8:0] e(input logic snd, input logic snz, input int left,
                                   input int used, input logic arm);
    return {snd, snz, 4'(left), 2'(used), arm};
  endfunction

  function automatic void add(input logic om, input logic sz, input logic st, input logic en,
                              input logic [15:0] cur, input logic [8:0] exp, input string name);
    vec_t v;
    v.om = om; v.sz = sz; v.st = st; v.en = en; v.cur = cur; v.exp = exp; v.name = name;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {sound_alarm, snoozing, snooze_left, snoozes_used, armed};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got snd=%0b snz=%0b left=%0d used=%0d arm=%0b, want snd=%0b snz=%0b left=%0d used=%0d arm=%0b",
               name, $time, got[8], got[7], got[6:3], got[2:1], got[0],
               exp[8], exp[7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic drive(input logic om, input logic sz, input logic st, input logic en,
                       input logic [15:0] cur);
    one_minute = om; snooze = sz; stop_alarm = st; alarm_enable = en; current_time = cur;
  endtask

  task automatic tick();
    @(posedge clk256);
    #1;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ring = 0; m_left = 0; m_used = 0; m_armed = 1'b0;
  endtask

  // Event-level model: applies one clock edge worth of the sequencing rules.
  task automatic model_step();
    case (m_mode)
      M_IDLE: if (alarm_enable && current_time == alarm_time) begin
        m_mode = M_RING; m_ring = 0; m_used = 0;
      end
      M_RING: begin
        if (!alarm_enable || stop_alarm) m_mode = M_DONE;
        else if (snooze && m_used < MAX_SNZ) begin
          m_mode = M_SNZ; m_left = SNZ_MIN; m_used++;
        end else if (one_minute) begin
          m_ring++;
          if (m_ring >= RING_TO) m_mode = M_DONE;
        end
      end
      M_SNZ: begin
        if (!alarm_enable || stop_alarm) begin
          m_mode = M_DONE; m_left = 0;
        end else if (one_minute) begin
          m_left--;
          if (m_left == 0) begin m_mode = M_RING; m_ring = 0; end
        end
      end
      default: if (alarm_enable && current_time != alarm_time) m_mode = M_IDLE;
    endcase
    m_armed = (m_mode == M_IDLE) && alarm_enable;
  endtask

  function automatic logic [8:0] model_exp();
    return e(m_mode == M_RING, m_mode == M_SNZ, (m_mode == M_SNZ) ? m_left : 0, m_used, m_armed);
  endfunction

  initial begin
    logic [15:0] other;
    int r;

    // Clock and reset
    reset = 1'b0; alarm_time = 16'h0630;
    drive(0, 0, 0, 1, 16'h0629);
    tick();
    check("reset_state", e(0, 0, 0, 0, 0));
    reset = 1'b1;

    // Directed vector table
    add(0, 0, 0, 1, 16'h0629, e(0, 0, 0, 0, 1), "idle_armed");
    add(0, 0, 0, 1, 16'h0630, e(1, 0, 0, 0, 0), "match_ring");
    for (int rnd = 1; rnd <= 3; rnd++) begin
      add(0, 1, 0, 1, 16'h0630, e(0, 1, 9, rnd, 0), "snooze_take");
      for (int k = 1; k <= 9; k++)
        add(1, 0, 0, 1, 16'h0630, (k < 9) ? e(0, 1, 9 - k, rnd, 0) : e(1, 0, 0, rnd, 0),
            "snooze_count");
    end
    add(0, 1, 0, 1, 16'h0630, e(1, 0, 0, 3, 0), "snooze_exhausted");
    for (int k = 1; k <= 10; k++)
      add(1, 0, 0, 1, 16'h0630, (k < 10) ? e(1, 0, 0, 3, 0) : e(0, 0, 0, 3, 0), "ring_timeout");
    add(0, 0, 0, 1, 16'h0630, e(0, 0, 0, 3, 0), "done_no_retrigger");
    add(0, 0, 0, 1, 16'h0631, e(0, 0, 0, 3, 1), "done_to_idle");
    add(0, 0, 0, 1, 16'h0630, e(1, 0, 0, 0, 0), "rering");
    add(0, 1, 1, 1, 16'h0630, e(0, 0, 0, 0, 0), "stop_beats_snooze");
    add(0, 0, 0, 1, 16'h0631, e(0, 0, 0, 0, 1), "idle_again");
    add(0, 0, 0, 0, 16'h0630, e(0, 0, 0, 0, 0), "disarmed_no_ring");
    add(0, 0, 0, 1, 16'h0630, e(1, 0, 0, 0, 0), "rearm_ring");
    add(0, 0, 0, 0, 16'h0630, e(0, 0, 0, 0, 0), "disable_kills");
    add(0, 0, 0, 0, 16'h0631, e(0, 0, 0, 0, 0), "done_held_disabled");
    add(0, 0, 0, 1, 16'h0631, e(0, 0, 0, 0, 1), "done_release");
    add(0, 0, 0, 1, 16'h0630, e(1, 0, 0, 0, 0), "ring_for_stop");
    add(0, 1, 0, 1, 16'h0630, e(0, 1, 9, 1, 0), "snooze_again");
    add(1, 0, 0, 1, 16'h0630, e(0, 1, 8, 1, 0), "snooze_minute");
    add(0, 0, 1, 1, 16'h0630, e(0, 0, 0, 1, 0), "stop_in_snooze");
    add(0, 0, 0, 1, 16'h0631, e(0, 0, 0, 1, 1), "back_idle");
    foreach (vq[i]) begin
      drive(vq[i].om, vq[i].sz, vq[i].st, vq[i].en, vq[i].cur);
      tick();
      check(vq[i].name, vq[i].exp);
    end

    // Reset while snoozing with five minutes left
    drive(0, 0, 0, 1, 16'h0630); tick(); check("hs_ring", e(1, 0, 0, 0, 0));
    drive(0, 1, 0, 1, 16'h0630); tick(); check("hs_snooze", e(0, 1, 9, 1, 0));
    for (int k = 0; k < 4; k++) begin drive(1, 0, 0, 1, 16'h0630); tick(); end
    check("hs_left5", e(0, 1, 5, 1, 0));
    drive(0, 0, 0, 1, 16'h0630);
    reset = 1'b0; #1;
    check("hs_async_reset", e(0, 0, 0, 0, 0));
    tick();
    check("hs_reset_held", e(0, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 16'h0631); reset = 1'b1; tick();
    check("hs_post_reset_idle", e(0, 0, 0, 0, 1));
    // Match already present when reset releases
    reset = 1'b0; #1;
    drive(0, 0, 0, 1, 16'h0630); reset = 1'b1; tick();
    check("hs_match_at_release", e(1, 0, 0, 0, 0));
    drive(0, 0, 1, 1, 16'h0631); tick(); check("hs_stop", e(0, 0, 0, 0, 0));

    // Random stimulus against the reference model
    reset = 1'b0; #1; model_reset(); check("rand_reset", model_exp());
    reset = 1'b1;
    alarm_time = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0; #1;
        model_reset();
        check("rand_reset", model_exp());
        reset = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) alarm_time = 16'($urandom_range(0, 16'h2359));
      other = alarm_time ^ 16'(1 << $urandom_range(0, 15));
      r = $urandom_range(0, 19);
      drive(r <= 5, r == 6, r == 7, $urandom_range(0, 39) != 0,
            ($urandom_range(0, 3) == 0) ? alarm_time : other);
      model_step();
      tick();
      check("rand", model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
